// File: rtl/maj_chain_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : maj_chain_sequencer
// Function : Time-multiplexed 7-input majority network evaluator; one shared
//            MAJ3 unit steps through a loaded node program, one node per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module maj_chain_sequencer #(
    parameter int NUM_IN    = 7,
    parameter int MAX_NODES = 8,
    parameter int IDX_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_addr,
    input  logic [3*(IDX_W+1)-1:0]   cfg_data,
    input  logic [3:0]               cfg_len,
    output logic                     cfg_err,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_IN-1:0]        in_x,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_y,
    output logic                     busy
);

    localparam int OP_W  = IDX_W + 1;
    localparam int K_W   = $clog2(MAX_NODES);
    localparam int SRC_N = 2 ** IDX_W;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_eval = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]            r_state;
    logic [K_W-1:0]        r_k;
    logic [3:0]            r_len;
    logic [NUM_IN-1:0]     r_x;
    logic [MAX_NODES-1:0]  r_w;
    logic                  r_y;
    logic                  r_err;
    logic [3*OP_W-1:0]     r_prog [MAX_NODES];

    logic                  w_addr_ok;
    logic                  w_cfg_ok;
    logic [3:0]            w_len_sat;
    logic [3*OP_W-1:0]     w_entry;
    logic [SRC_N-1:0]      w_src;
    logic                  w_a;
    logic                  w_b;
    logic                  w_c;
    logic                  w_maj;
    logic                  w_last;

    assign w_addr_ok = (32'(cfg_addr) < MAX_NODES);
    assign w_cfg_ok  = cfg_we && (r_state == c_idle) && w_addr_ok;
    assign w_len_sat = (32'(cfg_len) > MAX_NODES) ? 4'(MAX_NODES) : cfg_len;

    // Program storage has no reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (w_cfg_ok) begin
            r_prog[cfg_addr] <= cfg_data;
        end
    end

    // Operand source map: 0 = constant 0, then inputs, then node results,
    // any remaining index reads 0.
    always_comb begin
        w_src = '0;
        w_src[NUM_IN:1] = r_x;
        w_src[NUM_IN+MAX_NODES:NUM_IN+1] = r_w;
    end

    assign w_entry = r_prog[r_k];
    assign w_a = w_src[w_entry[IDX_W-1:0]]               ^ w_entry[IDX_W];
    assign w_b = w_src[w_entry[OP_W+IDX_W-1:OP_W]]       ^ w_entry[OP_W+IDX_W];
    assign w_c = w_src[w_entry[2*OP_W+IDX_W-1:2*OP_W]]   ^ w_entry[2*OP_W+IDX_W];
    assign w_maj  = (w_a & w_b) | (w_a & w_c) | (w_b & w_c);
    assign w_last = ((4'(r_k) + 4'd1) == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_idle;
            r_k     <= '0;
            r_len   <= '0;
            r_x     <= '0;
            r_w     <= '0;
            r_y     <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= cfg_we && !w_cfg_ok;
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_x   <= in_x;
                        r_len <= w_len_sat;
                        r_w   <= '0;
                        r_k   <= '0;
                        if (w_len_sat == 4'd0) begin
                            r_y     <= 1'b0;
                            r_state <= c_done;
                        end else begin
                            r_state <= c_eval;
                        end
                    end
                end
                c_eval: begin
                    r_w[r_k] <= w_maj;
                    r_k      <= r_k + 1'b1;
                    if (w_last) begin
                        r_y     <= w_maj;
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign busy      = (r_state != c_idle);
    assign out_valid = (r_state == c_done);
    assign out_y     = r_y;
    assign cfg_err   = r_err;

endmodule
`default_nettype wire
